// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and FSM state type for the instruction-memory loader
package imem_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int LEN_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        FINISH,
        ERROR
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs a little-endian byte stream into 32-bit words
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        full
);

    // Only the three bytes already received are stored; the fourth is merged on the fly.
    logic [23:0] word_q;
    logic [1:0]  count;

    assign word_next = {byte_in, word_q};
    assign full      = shift_en && (count == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            count  <= '0;
        end else if (clear) begin
            word_q <= '0;
            count  <= '0;
        end else if (shift_en) begin
            word_q <= word_next[31:8];
            count  <= count + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader writing instruction words into memory
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int IW = $clog2(DEPTH) + 1;

    state_t           state, state_next;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_rx;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_inc;
    logic             accept;
    logic             launch;
    logic             asm_full;
    logic [31:0]      asm_word;

    assign accept  = in_valid && in_ready;
    assign launch  = start && (state == IDLE || state == ERROR);
    assign idx_inc = idx + IW'(1);
    assign len_rx  = {in_data, len[7:0]};

    word_assembler u_word_assembler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (launch),
        .shift_en  (accept && state == DATA),
        .byte_in   (in_data),
        .word_next (asm_word),
        .full      (asm_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_next = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_next = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (len_rx == '0 || 32'(len_rx) > 32'(DEPTH)) state_next = ERROR;
                    else                                          state_next = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (asm_full) state_next = WRITE;
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (LEN_W'(idx_inc) == len) state_next = FINISH;
                else                        state_next = DATA;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERROR: begin
                err = 1'b1;
                if (launch) state_next = LEN_LO;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address and data are captured with the 4th byte so they are stable through WRITE and after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len     <= '0;
            idx     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (launch) begin
                len <= '0;
                idx <= '0;
            end else begin
                if (accept && state == LEN_LO) len[7:0]       <= in_data;
                if (accept && state == LEN_HI) len[LEN_W-1:8] <= in_data;
                if (state == WRITE)            idx            <= idx_inc;
            end
            if (asm_full) begin
                wr_data <= asm_word;
                wr_addr <= AW'({idx, 2'b00});
            end
        end
    end

endmodule
